// File: rtl/spi_dac_frame_rx_pkg.sv
// Shared constants and types for the SPI DAC frame receiver.
// Frame layout, LSB first on the wire: [3:0] cfg, [11:4] data, [15:12] pad (must be 0).
package spi_dac_pkg;

  localparam int FRAME_BITS_DEF = 16;

  localparam int CFG_LSB  = 0;
  localparam int CFG_W    = 4;
  localparam int DATA_LSB = 4;
  localparam int DATA_W   = 8;
  localparam int PAD_LSB  = 12;
  localparam int PAD_W    = 4;

  localparam int CNT_W   = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/spi_dac_frame_rx_sync_edge.sv
// Multi-flop synchronizer for one async pin, plus a delay flop for edge detection.
// Edge strobes are combinational from the delay flop and last for one clk cycle.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~dly_q;
  assign fall  = ~level & dly_q;

endmodule

// File: rtl/spi_dac_frame_rx.sv
// Oversampling mode-0 SPI slave that reassembles LSB-first DAC command frames and
// reports each one as either accepted (word_valid) or malformed (frame_err).
module spi_dac_frame_rx
  import spi_dac_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  n_CS,
  input  logic                  SCK,
  input  logic                  SDI,
  output logic [FRAME_BITS-1:0] word,
  output logic [CFG_W-1:0]      cfg,
  output logic [DATA_W-1:0]     data,
  output logic                  word_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int IDX_W = $clog2(FRAME_BITS);

  logic cs_level, cs_rise, cs_fall;
  logic sck_level_unused, sck_rise, sck_fall_unused;
  logic sdi_level, sdi_rise_unused, sdi_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk   (clk),
    .rst   (rst),
    .din   (n_CS),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk   (clk),
    .rst   (rst),
    .din   (SCK),
    .level (sck_level_unused),
    .rise  (sck_rise),
    .fall  (sck_fall_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clk   (clk),
    .rst   (rst),
    .din   (SDI),
    .level (sdi_level),
    .rise  (sdi_rise_unused),
    .fall  (sdi_fall_unused)
  );

  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  frame_ok;

  assign frame_ok = (bit_cnt == CNT_W'(FRAME_BITS)) && (shreg[PAD_LSB +: PAD_W] == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          // A CS fall wins over a coincident SCK rise: mode 0 has SCK low at select.
          if (cs_fall) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            shreg   <= '0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state <= IDLE;
            if (frame_ok) begin
              word       <= shreg;
              word_valid <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
          end else if (sck_rise) begin
            if (bit_cnt < CNT_W'(FRAME_BITS))
              shreg[bit_cnt[IDX_W-1:0]] <= sdi_level;
            // Saturate so over-long frames never alias back to a legal count.
            if (bit_cnt != CNT_W'(CNT_MAX))
              bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cfg  = word[CFG_LSB  +: CFG_W];
  assign data = word[DATA_LSB +: DATA_W];
  // The synced CS level is itself a flop output; inverting it keeps busy glitch-free.
  assign busy = ~cs_level;

endmodule

// File: tb/tb_spi_dac_frame_rx.sv
// Randomized bench for spi_dac_frame_rx against a frame-level reference model.
module tb_spi_dac_frame_rx;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        n_CS, SCK, SDI;
  logic [15:0] word;
  logic [3:0]  cfg;
  logic [7:0]  data;
  logic        word_valid, frame_err, busy;

  spi_dac_frame_rx #(.FRAME_BITS(16), .SYNC_STAGES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .n_CS       (n_CS),
    .SCK        (SCK),
    .SDI        (SDI),
    .word       (word),
    .cfg        (cfg),
    .data       (data),
    .word_valid (word_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: frame-level outcome only
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  logic [15:0] exp_word = '0;
  int          exp_err = 0;
  int          obs_err = 0;
  int          obs_both = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (word_valid) obs_q.push_back(word);
      if (frame_err) obs_err++;
      if (word_valid && frame_err) obs_both++;
    end
  end

  function automatic void model_frame(input logic [31:0] val, input int n);
    if (n == 16 && val[15:12] == 4'h0) begin
      exp_word = val[15:0];
      exp_q.push_back(val[15:0]);
    end else begin
      exp_err++;
    end
  endfunction

  // Called at a negedge; leaves the caller at a negedge.
  task automatic send_frame(input logic [31:0] val, input int n, input int half, input int gap);
    n_CS = 1'b0;
    repeat (half) @(negedge clk);
    chk("busy_in_frame", {31'b0, busy}, 32'd1);
    for (int i = 0; i < n; i++) begin
      SDI = val[i];
      repeat (half) @(negedge clk);
      SCK = 1'b1;
      repeat (half) @(negedge clk);
      SCK = 1'b0;
    end
    repeat (half) @(negedge clk);
    n_CS = 1'b1;
    model_frame(val, n);
    repeat (gap) @(negedge clk);
  endtask

  task automatic sync_check(input string tag);
    logic [15:0] e, o;
    repeat (S + 10) @(negedge clk);
    chk({tag, "_nvalid"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_vword"}, {16'b0, o}, {16'b0, e});
    end
    exp_q.delete();
    obs_q.delete();
    chk({tag, "_nerr"}, obs_err, exp_err);
    chk({tag, "_word"}, {16'b0, word}, {16'b0, exp_word});
    chk({tag, "_cfg"},  {28'b0, cfg},  {28'b0, exp_word[3:0]});
    chk({tag, "_data"}, {24'b0, data}, {24'b0, exp_word[11:4]});
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    int n, half, gap;
    rst = 1'b1; n_CS = 1'b0; SCK = 1'b0; SDI = 1'b0;
    repeat (4) @(negedge clk);
    // CS rises while in reset: never seen as a frame end
    n_CS = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_word",  {16'b0, word}, 32'h0);
    chk("rst_valid", {31'b0, word_valid}, 32'd0);
    chk("rst_err",   {31'b0, frame_err}, 32'd0);
    chk("rst_busy",  {31'b0, busy}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // SCK activity with CS deasserted is ignored
    for (int i = 0; i < 6; i++) begin
      SDI = i[0];
      SCK = 1'b1; repeat (4) @(negedge clk);
      SCK = 1'b0; repeat (4) @(negedge clk);
    end
    sync_check("idle_sck");

    send_frame(32'h078C, 16, 5, 5);  sync_check("f078c");
    send_frame(32'h7FFF, 15, 5, 5);  sync_check("short15");
    send_frame(32'h1078C, 17, 5, 5); sync_check("long17");
    send_frame(32'h1000, 16, 5, 5);  sync_check("pad");

    // Reset after 8 SCK rises mid-frame: no pulse, outputs back to zero
    n_CS = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      SDI = 1'b1;
      repeat (4) @(negedge clk); SCK = 1'b1;
      repeat (4) @(negedge clk); SCK = 1'b0;
    end
    rst = 1'b1; n_CS = 1'b1; SDI = 1'b0;
    repeat (S + 3) @(negedge clk);
    rst = 1'b0;
    exp_word = '0;
    sync_check("midrst");

    send_frame(32'h0FF0, 16, 5, 5);  sync_check("f0ff0");

    // Back-to-back with minimum CS-high gap
    send_frame(32'h0123, 16, S + 1, S + 1);
    send_frame(32'h0ABC, 16, S + 1, S + 1);
    sync_check("b2b");

    for (int f = 0; f < 30; f++) begin
      v = $urandom;
      if ($urandom_range(0, 2) != 0) v[15:12] = 4'h0;
      n = ($urandom_range(0, 1) == 1) ? 16 : int'($urandom_range(12, 20));
      half = $urandom_range(S + 1, 6);
      gap  = $urandom_range(S + 1, 8);
      send_frame(v, n, half, gap);
      if (f % 3 == 2) sync_check("rand");
    end
    sync_check("rand_end");

    chk("valid_err_excl", obs_both, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
